argmax_hex_out: RTL
===================

// Module: argmax_hex_out
// PURPOSE
//  Final output stage of the FPGA neural network. Consumes the output-layer scores as a
//  valid/ready stream, one score per class per frame, and selects the class with the maximum
//  signed score. Registers that class index and its score, and drives HEX0 (7-seg, active-low)
//  with the predicted digit. Sits downstream of the output-layer neuron array, upstream of board pins.
// PARAMETERS
//  NUM_CLASSES  10  scores per frame (classes 0..NUM_CLASSES-1); legal range 2..16
//  DATA_W       16  score width, signed two's complement (Q8.8)
//  IDX_W        4   class index width; must satisfy 2**IDX_W >= NUM_CLASSES
// PORTS
//  CLOCK_50   in   1       single system clock, rising edge
//  KEY        in   1       reset: asynchronous, active-low (board KEY[0])
//  in_valid   in   1       score beat valid
//  in_ready   out  1       stage can accept a beat
//  in_data    in   DATA_W  signed score of current class
//  in_last    in   1       marks last beat of frame
//  out_valid  out  1       one-cycle pulse: new result registered
//  out_class  out  IDX_W   index of max score (held until next result)
//  out_score  out  DATA_W  max score value (held)
//  err_len    out  1       high with out_valid if frame length != NUM_CLASSES (held until next result)
//  HEX0       out  7       segments {g,f,e,d,c,b,a}, active-low
// BEHAVIOUR
//  Reset (KEY=0, async): state=IDLE, in_ready=0 while KEY low, out_valid=0, out_class=0,
//   out_score=0, err_len=0, HEX0=7'h7F (blank). Reset mid-frame abandons the frame; nothing reported.
//  Handshake: beat accepted on rising edge when in_valid && in_ready. in_data/in_last are sampled
//   only on acceptance. in_ready is registered-state based, never depends on in_valid.
//  FSM:
//   IDLE: in_ready=1. On accept: best<=in_data, best_idx<=0, cnt<=1. in_last ? ->DONE : ->SCAN.
//   SCAN: in_ready=1. On accept: if in_data > best (strict signed), best<=in_data, best_idx<=cnt.
//         cnt saturates at NUM_CLASSES; beats with cnt>=NUM_CLASSES are accepted but never compared.
//         in_last accepted -> DONE.
//   DONE: in_ready=0 for exactly one cycle; out_valid=1; ->IDLE.
//  Result registers (out_class, out_score, err_len, HEX0) load on the edge entering DONE, i.e.,
//   out_valid is high the cycle after the last beat is accepted (latency 1); the last beat's
//   compare is included in the result.
//  Ties: the earlier (lower) index wins.
//  err_len=1 if final beat count != NUM_CLASSES (short, single-beat, or overlong frame);
//   class/score still reported from beats compared.
//  HEX0: hex digit decode of out_class (0-9, A-F); stays at last value between frames.
//  Back-to-back frames: one bubble (DONE) between frames; throughput NUM_CLASSES+1 cycles/frame.
//  Compare is full DATA_W signed; no saturation or truncation of scores.
// STRUCTURE
//  Shared include nn_defs.vh: FSM state encodings (IDLE/SCAN/DONE), SEG_BLANK=7'h7F,
//   default DATA_W/NUM_CLASSES shared with neuron layers.
//  One sub-module: seg7_hex_decoder (4-bit nibble -> 7-bit active-low segments, combinational),
//   output registered in this block. Reused by other HEX displays.
// TESTING
//  1 Reset: KEY=0 at t=0, release at 10 ns -> HEX0=7'h7F, out_valid=0, out_class=0, in_ready=1.
//  2 Frame 10 scores {5,-3,40,7,40,0,-100,2,1,39}, last on beat 9 -> out_valid 1 cycle after,
//    out_class=2 (tie with idx 4 keeps 2), out_score=40, err_len=0, HEX0=7'h24.
//  3 All-negative frame, max 16'hFF00 (-1.0) at idx 9 -> out_class=9, HEX0=7'h10 (signed compare).
//  4 Short frame: 4 beats, last on 4th, max at idx 3 -> out_class=3, err_len=1;
//    next good frame clears err_len.
//  5 Gaps: in_valid toggled randomly within a frame; back-to-back frames -> in_ready low exactly
//    1 cycle per frame, results identical to gap-free run.
//  6 Assert KEY=0 mid-frame (beat 5) -> outputs return to reset values immediately;
//    following full frame reports correctly.

Source files
------------

// File: rtl/argmax_hex_out_pkg.sv
// Shared definitions for the network output stage: FSM encodings, blank segment pattern, default widths.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package argmax_hex_out_pkg;

  // Defaults shared with the neuron layers upstream
  localparam int DEF_NUM_CLASSES = 10;
  localparam int DEF_DATA_W      = 16;
  localparam int DEF_IDX_W       = 4;

  // All segments off (active-low display)
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/argmax_hex_out_seg7.sv
// Hex nibble to 7-segment pattern {g,f,e,d,c,b,a}, active-low.
// Latency: combinational.
// Backpressure: none.
module seg7_hex_decoder (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Lookup of the glyph for each hex digit
  always_comb begin
    seg = 7'h7F;
    case (nibble)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
  end

endmodule

// File: rtl/argmax_hex_out.sv
// Picks the class with the largest signed score in each frame, holds index/score and shows it on HEX0.
// Latency: result registered 1 cycle after the last beat is accepted (out_valid pulses then).
// Backpressure: in_ready drops for exactly the one result cycle between frames, and while KEY is low.
module argmax_hex_out
  import argmax_hex_out_pkg::*;
#(
  parameter int NUM_CLASSES = DEF_NUM_CLASSES,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int IDX_W       = DEF_IDX_W
) (
  input  logic                     CLOCK_50,
  input  logic                     KEY,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     in_last,
  output logic                     out_valid,
  output logic [IDX_W-1:0]         out_class,
  output logic [DATA_W-1:0]        out_score,
  output logic                     err_len,
  output logic [6:0]               HEX0
);

  // One extra bit so the beat counter can hold NUM_CLASSES itself (e.g. 16 with IDX_W=4)
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_CLASSES);

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic signed [DATA_W-1:0]  best_q, best_d;
  logic [IDX_W-1:0]          best_idx_q, best_idx_d;
  logic                      ovf_q, ovf_d;
  logic [IDX_W-1:0]          class_q, class_d;
  logic [DATA_W-1:0]         score_q, score_d;
  logic                      err_q, err_d;
  logic [6:0]                hex_q, hex_d;
  logic [6:0]                seg_nxt;
  logic                      accept;

  // Decode the winner including this beat, so HEX0 loads together with out_class
  seg7_hex_decoder u_seg7 (
    .nibble (4'(best_idx_d)),
    .seg    (seg_nxt)
  );

  // State and datapath registers; reset abandons any partial frame
  always_ff @(posedge CLOCK_50 or negedge KEY) begin
    if (!KEY) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      best_q     <= '0;
      best_idx_q <= '0;
      ovf_q      <= 1'b0;
      class_q    <= '0;
      score_q    <= '0;
      err_q      <= 1'b0;
      hex_q      <= SEG_BLANK;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      best_q     <= best_d;
      best_idx_q <= best_idx_d;
      ovf_q      <= ovf_d;
      class_q    <= class_d;
      score_q    <= score_d;
      err_q      <= err_d;
      hex_q      <= hex_d;
    end
  end

  // Next-state: a frame ends on the accepted last beat, followed by a single DONE bubble
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = in_last ? ST_DONE : ST_SCAN;
      ST_SCAN: if (accept && in_last) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs depend only on registered state (and the reset pin)
  always_comb begin
    in_ready  = KEY && (state_q != ST_DONE);
    out_valid = (state_q == ST_DONE);
  end

  assign accept = in_valid && in_ready;

  // Running max: first beat seeds it, later beats replace only when strictly larger
  always_comb begin
    cnt_d      = cnt_q;
    best_d     = best_q;
    best_idx_d = best_idx_q;
    ovf_d      = ovf_q;
    if (accept) begin
      if (state_q == ST_IDLE) begin
        best_d     = in_data;
        best_idx_d = '0;
        cnt_d      = CNT_W'(1);
        ovf_d      = 1'b0;
      end else if (cnt_q >= CNT_FULL) begin
        // Beats past the class count are swallowed but remembered as a length error
        ovf_d = 1'b1;
      end else begin
        if (in_data > best_q) begin
          best_d     = in_data;
          best_idx_d = IDX_W'(cnt_q);
        end
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Result registers load only on the last beat and hold between frames
  always_comb begin
    class_d = class_q;
    score_d = score_q;
    err_d   = err_q;
    hex_d   = hex_q;
    if (accept && in_last) begin
      class_d = best_idx_d;
      score_d = best_d;
      err_d   = ovf_d || (cnt_d != CNT_FULL);
      hex_d   = seg_nxt;
    end
  end

  assign out_class = class_q;
  assign out_score = score_q;
  assign err_len   = err_q;
  assign HEX0      = hex_q;

endmodule
